// File: rtl/serial_bit_serializer_pkg.sv
// Shared definitions for the serial bit serializer: FSM state encoding and
// the bit-counter width helper. The downstream detector uses the same encodings.
package serial_bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter width for a mod-width counter; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Mod-WIDTH bit counter with clear, enable and terminal-count flag.
// tc marks the last bit of the word currently on the serial output.
module serial_bit_counter
  import serial_bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_bit_serializer.sv
// Parallel-to-serial feeder: takes WIDTH-bit words over valid/ready and
// shifts them out one bit per clock. A one-word holding register lets a
// word queued during shifting follow the current one without an idle gap.
module serial_bit_serializer
  import serial_bit_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             last_bit;

  // Bit that leaves first from a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its leading bit consumed, so the next bit sits in the first position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready depends only on registered state and reset, never on load_valid.
  assign load_ready = !rst && !hold_full_q;
  assign accept     = load_valid && load_ready;

  // The counter idles at zero and advances once per shifted bit.
  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q == ST_IDLE),
    .en (state_q == ST_SHIFT),
    .tc (last_bit)
  );

  // Next-state, datapath and registered-output decisions.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        out_d       = IDLE_LEVEL;
        out_valid_d = 1'b0;
        if (accept) begin
          state_d       = ST_SHIFT;
          shreg_d       = shift_word(load_data);
          out_d         = first_bit(load_data);
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          shreg_d     = shift_word(shreg_q);
          out_d       = first_bit(shreg_q);
          out_valid_d = 1'b1;
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Queued word follows immediately; ready is low so no accept here.
          shreg_d       = shift_word(hold_q);
          out_d         = first_bit(hold_q);
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          hold_full_d   = 1'b0;
        end else if (accept) begin
          shreg_d       = shift_word(load_data);
          out_d         = first_bit(load_data);
          out_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          out_d       = IDLE_LEVEL;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT) || hold_full_d;
  end

  // Control state and outputs, cleared asynchronously so a reset drops any word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_full_q   <= 1'b0;
      out_q         <= IDLE_LEVEL;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_full_q   <= hold_full_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // Word storage; contents are meaningless unless qualified by state/hold_full.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    hold_q  <= hold_d;
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule
